// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the
// data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int CNT_W = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: single-port word array, synchronous
// write, combinational read, contents never reset.
module dmem_word_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory
// target for the MEM stage, fixed wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IW = idx_w(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'(WAIT_CYCLES);
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic               r_err;
  logic [IW-1:0]      r_idx;
  logic [31:0]        r_wdata;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic [31:0]        r_resp_rdata;

  logic               w_idle;
  logic               w_req_err;
  logic [IW-1:0]      w_req_idx;
  logic               w_go_resp;
  logic               w_we;
  logic               w_err;
  logic [IW-1:0]      w_idx;
  logic [31:0]        w_wdata;
  logic               w_ram_we;
  logic [31:0]        w_ram_rdata;
  logic [31:0]        w_ld_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_req_idx = req_addr[IW+1:2];
  assign w_req_err = (req_addr[1:0] != 2'b00) |
                     (|req_addr[31:IW+2]);

  // Zero-wait builds complete on the accept edge, so the
  // live request feeds the array instead of the latches.
  assign w_go_resp = w_idle ?
                     (req_valid & ZERO_WAIT) :
                     ((r_state == ST_WAIT) &
                      (r_cnt == CNT_W'(1)));

  assign w_we    = w_idle ? req_we    : r_we;
  assign w_err   = w_idle ? w_req_err : r_err;
  assign w_idx   = w_idle ? w_req_idx : r_idx;
  assign w_wdata = w_idle ? req_wdata : r_wdata;

  assign w_ram_we  = w_go_resp & w_we & ~w_err;
  assign w_ld_data = (w_we | w_err) ? 32'h0 : w_ram_rdata;

  dmem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_go_resp;
      r_resp_err   <= w_go_resp & w_err;
      if (w_go_resp) begin
        r_resp_rdata <= w_ld_data;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_err   <= w_req_err;
            r_idx   <= w_req_idx;
            r_wdata <= req_wdata;
            r_cnt   <= WAIT_INIT;
            r_state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_go_resp) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign busy       = ~w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the MEM-stage data-memory interface: accepts one word read or write request at a time from the pipeline's memory stage and answers after a fixed number of wait states. It replaces the zero-latency data memory with a handshaked, multi-cycle target, so the pipeline can be verified against realistic memory latency. It sits between the EX/MEM register outputs (address, store data, read/write controls) and the MEM/WB register inputs (load data). Its `busy` output drives the pipeline stall.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words stored; must be a power of two, at least 4.
- `WAIT_CYCLES`, 2: wait states between accept and response; range 0..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address; bits [1:0] must be 00.
- `req_wdata`  in  32  store data; ignored for reads.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load data; valid only while `resp_valid` is 1.
- `resp_err`  out  1  the request was misaligned or out of range; qualified by `resp_valid`.
- `busy`  out  1  a transaction is in flight; the pipeline stalls on it.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_we`, `req_addr`, `req_wdata`.
  - Compute `err` = (addr[1:0]≠0) OR (addr[31:2] ≥ DEPTH_WORDS).
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or straight to RESP if WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reads 1, the next edge enters RESP.
  - On that same edge, a non-error write commits to the array, and `resp_rdata` is loaded:
    - non-error read: array word at addr[31:2];
    - write or error: 0.
- RESP:
  - `resp_valid`=1 for exactly one cycle; `resp_err` = latched `err`.
  - Next state is IDLE unconditionally; there is no response back-pressure.
- Error requests never modify storage.
- `busy` = (state ≠ IDLE); `req_ready` = (state = IDLE).
- Requests presented while not ready are ignored. The requester holds them until `req_ready`.
- Only word accesses are supported; there are no byte enables.

## Timing
- Accept on edge E0, i.e. `req_valid` and `req_ready` both high in the cycle before E0.
- `resp_valid` is high in cycle E0+WAIT_CYCLES+1. That is latency WAIT_CYCLES+1, or 1 when WAIT_CYCLES=0.
- `req_ready` returns high in the cycle after RESP.
- Maximum throughput: one transaction per WAIT_CYCLES+2 cycles.
- Read-after-write: a read accepted after a write's RESP returns the new data.
- Reset asserted, at any time including mid-transaction:
  - state→IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `busy`=0, `req_ready`=1 (combinational from state);
  - an uncommitted write is dropped;
  - array contents are not cleared.
- After reset deasserts, the first accept can occur on the first rising edge.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - WAIT counter width constant (4);
  - word-index helper width = log2(DEPTH_WORDS).
- Sub-module `dmem_word_ram`:
  - single-port, synchronous-write, combinational-read array (DEPTH_WORDS × 32);
  - no reset on contents.
- The top holds the FSM, wait counter, request latches, range/alignment check and response registers.

## Test plan
All scenarios use WAIT_CYCLES=2 and DEPTH_WORDS=256 unless stated.
- Write then read:
  - write addr 0x0000_0010, data 0xDEAD_BEEF → `resp_valid` 3 cycles after accept, `resp_err`=0;
  - read 0x10 → `resp_rdata`=0xDEAD_BEEF.
- Misaligned: write 0x0000_0012, data 0x1234_5678 → `resp_err`=1, `resp_rdata`=0; a later read of 0x10 still returns 0xDEAD_BEEF.
- Out of range: read 0x0000_0400 (word 256) → `resp_err`=1, `resp_rdata`=0.
- Back-to-back: `req_valid` held high with reads to 0x0, 0x4, 0x8 → accepts spaced exactly 4 cycles; `busy` is low only in the accept cycles.
- Reset mid-write:
  - write 0x20 = 0xAAAA_5555, then assert `reset` during WAIT → `resp_valid` never pulses, `busy`=0 immediately;
  - a later read of 0x20 returns the prior content, not 0xAAAA_5555.
- WAIT_CYCLES=0 build: read accepted on edge E0 → `resp_valid` in the cycle right after E0; write-then-read sequence correct.
